// File: rtl/mips_pipeline_pkg.sv
// Shared pipeline types for the MIPS core: memory-stage FSM states and
// register-file index width.
package mips_pipeline_pkg;

  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    word_t;

endpackage

// File: rtl/memory_writeback_register.sv
// Memory/Writeback pipeline flop bank. A bubble clears the control bits and
// holds the data fields; read data is only replaced when a load completes.
module memory_writeback_register
  import mips_pipeline_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     bubble,
  input  logic     read_capture,
  input  logic     register_write_next,
  input  logic     memory_to_register_next,
  input  word_t    alu_output_next,
  input  word_t    alu_hi_output_next,
  input  word_t    alu_lo_output_next,
  input  word_t    read_data_next,
  input  reg_idx_t write_register_next,
  output logic     register_write_reg,
  output logic     memory_to_register_reg,
  output word_t    alu_output_reg,
  output word_t    alu_hi_output_reg,
  output word_t    alu_lo_output_reg,
  output word_t    read_data_reg,
  output reg_idx_t write_register_reg
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      register_write_reg     <= 1'b0;
      memory_to_register_reg <= 1'b0;
      alu_output_reg         <= '0;
      alu_hi_output_reg      <= '0;
      alu_lo_output_reg      <= '0;
      read_data_reg          <= '0;
      write_register_reg     <= '0;
    end else if (bubble) begin
      register_write_reg     <= 1'b0;
      memory_to_register_reg <= 1'b0;
    end else begin
      register_write_reg     <= register_write_next;
      memory_to_register_reg <= memory_to_register_next;
      alu_output_reg         <= alu_output_next;
      alu_hi_output_reg      <= alu_hi_output_next;
      alu_lo_output_reg      <= alu_lo_output_next;
      write_register_reg     <= write_register_next;
      if (read_capture) begin
        read_data_reg <= read_data_next;
      end
    end
  end

endmodule

// File: rtl/memory_writeback_stage.sv
// MIPS memory stage: drives the data bus for loads/stores, stalls the pipe on
// wait states and feeds the Memory/Writeback register.
module memory_writeback_stage
  import mips_pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_memory,
  input  logic        register_write_memory,
  input  logic        memory_to_register_memory,
  input  logic        memory_to_write_memory,
  input  logic [31:0] ALU_output_memory,
  input  logic [31:0] ALU_HI_output_memory,
  input  logic [31:0] ALU_LO_output_memory,
  input  logic [31:0] write_data_memory,
  input  logic [4:0]  write_register_memory,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest,
  output logic        stall_memory,
  output logic        register_write_writeback,
  output logic        memory_to_register_writeback,
  output logic [31:0] ALU_output_writeback,
  output logic [31:0] ALU_HI_output_writeback,
  output logic [31:0] ALU_LO_output_writeback,
  output logic [31:0] read_data_writeback,
  output logic [4:0]  write_register_writeback
);

  mem_state_e state_reg;
  logic       load_op;
  logic       store_op;
  logic       memory_op;
  logic       load_done;
  logic       register_write_next;

  // Store wins when both load and store are flagged.
  assign store_op  = valid_memory & memory_to_write_memory;
  assign load_op   = valid_memory & memory_to_register_memory & ~memory_to_write_memory;
  assign memory_op = load_op | store_op;

  // Upstream is frozen while stalled, so the live inputs are the held request
  // in WAIT. Gating with reset_n drops the request the moment reset asserts.
  assign data_read      = reset_n & load_op;
  assign data_write     = reset_n & store_op;
  assign data_address   = {ALU_output_memory[31:2], 2'b00};
  assign data_writedata = write_data_memory;

  assign stall_memory = reset_n & data_waitrequest &
                        ((state_reg == IDLE && memory_op) || (state_reg == WAIT));

  assign load_done = data_read & ~data_waitrequest;

  assign register_write_next = valid_memory & register_write_memory &
                               ~(memory_to_register_memory & memory_to_write_memory);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (memory_op && data_waitrequest) state_reg <= WAIT;
        WAIT:    if (!data_waitrequest)             state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  memory_writeback_register u_wb_reg (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .bubble                  (stall_memory),
    .read_capture            (load_done),
    .register_write_next     (register_write_next),
    .memory_to_register_next (load_op),
    .alu_output_next         (ALU_output_memory),
    .alu_hi_output_next      (ALU_HI_output_memory),
    .alu_lo_output_next      (ALU_LO_output_memory),
    .read_data_next          (data_readdata),
    .write_register_next     (write_register_memory),
    .register_write_reg      (register_write_writeback),
    .memory_to_register_reg  (memory_to_register_writeback),
    .alu_output_reg          (ALU_output_writeback),
    .alu_hi_output_reg       (ALU_HI_output_writeback),
    .alu_lo_output_reg       (ALU_LO_output_writeback),
    .read_data_reg           (read_data_writeback),
    .write_register_reg      (write_register_writeback)
  );

endmodule

// File: doc/memory_writeback_stage.md
MEMORY_WRITEBACK_STAGE -- requirements
Module: memory_writeback_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, as follows:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
REQ-002 Inputs from the Execute/Memory pipeline register SHALL be:
- valid_memory  input  1  stage holds a live instruction.
- register_write_memory  input  1  instruction writes the register file.
- memory_to_register_memory  input  1  load.
- memory_to_write_memory  input  1  store.
- ALU_output_memory  input  32  address or ALU result.
- ALU_HI_output_memory  input  32  HI result.
- ALU_LO_output_memory  input  32  LO result.
- write_data_memory  input  32  store data.
- write_register_memory  input  5  destination register.
REQ-003 The data-bus ports SHALL be:
- data_address  output  32  word address.
- data_read  output  1  read request.
- data_write  output  1  write request.
- data_writedata  output  32  store data.
- data_readdata  input  32  load data.
- data_waitrequest  input  1  slave not ready.
REQ-004 The pipeline-control port SHALL be stall_memory  output  1, which freezes all upstream stages.
REQ-005 The registered Memory/Writeback outputs SHALL be:
- register_write_writeback  1
- memory_to_register_writeback  1
- ALU_output_writeback  32
- ALU_HI_output_writeback  32
- ALU_LO_output_writeback  32
- read_data_writeback  32
- write_register_writeback  5

Function
REQ-006 The FSM SHALL have exactly two states: IDLE and WAIT.
REQ-007 A memory op SHALL be valid_memory=1 with memory_to_register_memory=1 or memory_to_write_memory=1.
REQ-008 In IDLE with a memory op, the block SHALL drive the bus request combinationally in the same cycle:
- data_read = load and not store.
- data_write = store.
- data_address = {ALU_output_memory[31:2], 2'b00}.
- data_writedata = write_data_memory.
REQ-009 If load and store are both set, the store SHALL win: data_read=0, and register_write_writeback is forced to 0 on capture.
REQ-010 stall_memory SHALL equal the OR of two terms: (memory op in IDLE and data_waitrequest=1), and (state=WAIT and data_waitrequest=1).
REQ-011 IDLE SHALL move to WAIT when a memory op meets data_waitrequest=1.
REQ-012 WAIT SHALL hold the request and address stable, and SHALL return to IDLE at the first edge sampling data_waitrequest=0.
REQ-013 The transaction SHALL complete in the cycle data_waitrequest=0 with a request asserted.
REQ-014 read_data_writeback SHALL capture data_readdata only on load completion, and SHALL hold its value otherwise.
REQ-015 The writeback register SHALL capture the stage inputs on each edge where stall_memory=0.
REQ-016 When stall_memory=1, the writeback register SHALL load a bubble: register_write_writeback=0 and memory_to_register_writeback=0. The other data fields hold.
REQ-017 valid_memory=0 SHALL produce a bubble with no bus request.
REQ-018 Load latency SHALL be one cycle with zero wait states, and 1+N cycles with N wait states.
REQ-019 Back-to-back memory ops SHALL complete one per cycle when data_waitrequest=0.
REQ-020 data_read and data_write SHALL never both be 1.

Reset
REQ-021 While reset_n=0, all writeback outputs SHALL be 0, state SHALL be IDLE, and data_read, data_write and stall_memory SHALL be 0.
REQ-022 Reset asserted mid-WAIT SHALL drop the bus request immediately and asynchronously; the transaction is abandoned.
REQ-023 After reset_n rises, the first edge SHALL behave as IDLE.

Structure
REQ-024 The state enum (IDLE, WAIT) and the register-index width (5) SHALL live in the shared package mips_pipeline_pkg.
REQ-025 The flop bank SHALL be a sub-module, memory_writeback_register, with a bubble input. The FSM and bus logic stay in memory_writeback_stage.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Zero-wait load: ALU_output_memory=0x0000_1006, readdata=0xDEAD_BEEF, waitrequest=0 -> data_address=0x0000_1004, read=1 for 1 cycle, stall=0; next cycle read_data_writeback=0xDEAD_BEEF, memory_to_register_writeback=1.
- Two-wait store: write_data=0x1234_5678, waitrequest=1,1,0 -> data_write=1 for 3 cycles, stall=1 for 2 cycles, two bubbles (register_write_writeback=0), state returns to IDLE.
- Load plus store both set -> data_write=1, data_read=0, register_write_writeback=0.
- ALU op, register_write=1, write_register=5'd9, ALU_output=0x42 -> no bus request; next cycle ALU_output_writeback=0x42, write_register_writeback=9.
- reset_n pulled low in WAIT -> data_read drops within the same cycle, all outputs 0; after release, a zero-wait load completes normally.
- Three consecutive zero-wait loads -> three captures on consecutive edges, stall never asserted.
